// File: rtl/data_c_pipe_intc_s2m.sv
// ---------------------------------------------------------------------------
// data_c_pipe_intc_s2m
//
// Single-source to multi-sink frame router. It takes the merged stream from
// the upstream many-to-one interconnect and steers each whole frame to one of
// NUM sink ports, using the destination index sampled on the frame's first
// beat. Frames whose destination is out of range are drained and counted.
//
// The output side is a two-entry buffer (out register + skid register), so
// that m_valid/m_data/m_last and s_ready all come straight from flops. This
// sustains one beat per cycle while the target sink holds m_ready high.
//
// Ports:
//   clock     rising-edge clock
//   rst       synchronous, active-high reset
//   s_data    upstream beat data
//   s_valid   upstream beat valid
//   s_last    final beat of the upstream frame
//   s_addr    destination index, used only on the first beat of a frame
//   s_ready   upstream ready (registered)
//   m_data    beat data, broadcast to every sink
//   m_last    final-beat flag, broadcast to every sink
//   m_valid   one-hot valid, bit i addresses sink i
//   m_ready   per-sink ready
//   drop_err  one-cycle pulse when a frame with an illegal index is opened
//   drop_cnt  saturating count of dropped frames
// ---------------------------------------------------------------------------
module data_c_pipe_intc_s2m #(
  parameter int NUM   = 4,
  parameter int DSIZE = 32,
  parameter int NSIZE = (NUM <= 2) ? 1 : $clog2(NUM)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [DSIZE-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_last,
  input  logic [NSIZE-1:0] s_addr,
  output logic             s_ready,
  output logic [DSIZE-1:0] m_data,
  output logic             m_last,
  output logic [NUM-1:0]   m_valid,
  input  logic [NUM-1:0]   m_ready,
  output logic             drop_err,
  output logic [15:0]      drop_cnt
);

  localparam int unsigned NUM_U = NUM;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } route_state_t;

  route_state_t     state_q;
  route_state_t     state_d;
  logic [NSIZE-1:0] route_q;
  logic [NSIZE-1:0] route_d;

  // Beat currently presented upstream, and what the route FSM decided for it
  logic             accept;
  logic             addr_ok;
  logic             push;
  logic [NSIZE-1:0] push_route;
  logic             drop_open;

  // Output entry: drives the sink side directly
  logic [DSIZE-1:0] out_data;
  logic             out_last;
  logic [NSIZE-1:0] out_route;
  logic             out_vld;

  // Skid entry: catches the beat accepted while the out entry was stalled
  logic [DSIZE-1:0] skid_data;
  logic             skid_last;
  logic [NSIZE-1:0] skid_route;
  logic             skid_vld;

  // Buffer control decisions for this cycle
  logic             pop;
  logic             load_out_in;
  logic             load_out_skid;
  logic             load_skid;
  logic             out_vld_d;
  logic             skid_vld_d;

  assign accept  = s_valid && s_ready;
  assign addr_ok = 32'(s_addr) < NUM_U;

  assign m_data  = out_data;
  assign m_last  = out_last;

  // One-hot sink valid decoded purely from the out register, so it never
  // depends on m_ready.
  always_comb begin
    m_valid = '0;
    if (out_vld) begin
      for (int i = 0; i < NUM; i++) begin
        if (out_route == NSIZE'(i)) begin
          m_valid[i] = 1'b1;
        end
      end
    end
  end

  // m_valid is one-hot, so the pop is simply "the addressed sink is ready".
  assign pop = |(m_valid & m_ready);

  // Route FSM state register. The locked route only matters in LOCK.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Route FSM next state. The first beat of a frame either opens a route or
  // opens a drop; a single-beat frame (s_last on the first beat) is handled
  // completely in IDLE and never leaves it.
  always_comb begin
    state_d    = state_q;
    route_d    = route_q;
    push       = 1'b0;
    push_route = route_q;
    drop_open  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (addr_ok) begin
            push       = 1'b1;
            push_route = s_addr;
            route_d    = s_addr;
            state_d    = s_last ? IDLE : LOCK;
          end else begin
            drop_open  = 1'b1;
            state_d    = s_last ? IDLE : DROP;
          end
        end
      end
      LOCK: begin
        if (accept) begin
          push       = 1'b1;
          push_route = route_q;
          if (s_last) begin
            state_d = IDLE;
          end
        end
      end
      DROP: begin
        if (accept && s_last) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Buffer steering. A new beat goes straight to the out entry whenever that
  // entry is free or leaving this cycle; otherwise it parks in the skid.
  // While the skid is full s_ready is low, so a push and a skid refill cannot
  // normally coincide; the push is still kept rather than lost if they did.
  always_comb begin
    load_out_in   = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    out_vld_d     = out_vld;
    skid_vld_d    = skid_vld;
    if (pop && skid_vld) begin
      load_out_skid = 1'b1;
      out_vld_d     = 1'b1;
      skid_vld_d    = push;
      load_skid     = push;
    end else if (pop || !out_vld) begin
      load_out_in   = push;
      out_vld_d     = push;
    end else if (push) begin
      load_skid     = 1'b1;
      skid_vld_d    = 1'b1;
    end
  end

  // Buffer registers and the registered upstream ready. s_ready reflects
  // whether the skid will be free next cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      out_data   <= '0;
      out_last   <= 1'b0;
      out_route  <= '0;
      out_vld    <= 1'b0;
      skid_data  <= '0;
      skid_last  <= 1'b0;
      skid_route <= '0;
      skid_vld   <= 1'b0;
      s_ready    <= 1'b0;
    end else begin
      out_vld  <= out_vld_d;
      skid_vld <= skid_vld_d;
      s_ready  <= !skid_vld_d;
      if (load_out_skid) begin
        out_data  <= skid_data;
        out_last  <= skid_last;
        out_route <= skid_route;
      end else if (load_out_in) begin
        out_data  <= s_data;
        out_last  <= s_last;
        out_route <= push_route;
      end
      if (load_skid) begin
        skid_data  <= s_data;
        skid_last  <= s_last;
        skid_route <= push_route;
      end
    end
  end

  // Drop reporting: one pulse per illegal frame, counter sticks at all-ones.
  always_ff @(posedge clock) begin
    if (rst) begin
      drop_err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      drop_err <= drop_open;
      if (drop_open && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_c_pipe_intc_s2m.sv
// ---------------------------------------------------------------------------
// tb_data_c_pipe_intc_s2m
//
// Directed bench for the frame router. A NUM=4 instance carries the routing,
// ordering and backpressure traffic; a NUM=3 instance shares the upstream
// data/last/addr and sink ready lines but has its own s_valid, so an index of
// 3 is illegal there and exercises the drop path.
// ---------------------------------------------------------------------------
module tb_data_c_pipe_intc_s2m;

  logic        clock = 1'b0;
  logic        rst;
  logic [31:0] s_data;
  logic        s_valid4;
  logic        s_valid3;
  logic        s_last;
  logic [1:0]  s_addr;
  logic [3:0]  m_ready;

  logic        s_ready4;
  logic [31:0] m_data4;
  logic        m_last4;
  logic [3:0]  m_valid4;
  logic        drop_err4;
  logic [15:0] drop_cnt4;

  logic        s_ready3;
  logic [31:0] m_data3;
  logic        m_last3;
  logic [2:0]  m_valid3;
  logic        drop_err3;
  logic [15:0] drop_cnt3;

  int n_cmp = 0;
  int n_err = 0;
  int beat_sink;

  typedef struct {
    int          sink;
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  exp_t head;

  data_c_pipe_intc_s2m #(.NUM(4), .DSIZE(32)) dut4 (
    .clock    (clock),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid4),
    .s_last   (s_last),
    .s_addr   (s_addr),
    .s_ready  (s_ready4),
    .m_data   (m_data4),
    .m_last   (m_last4),
    .m_valid  (m_valid4),
    .m_ready  (m_ready),
    .drop_err (drop_err4),
    .drop_cnt (drop_cnt4)
  );

  data_c_pipe_intc_s2m #(.NUM(3), .DSIZE(32)) dut3 (
    .clock    (clock),
    .rst      (rst),
    .s_data   (s_data),
    .s_valid  (s_valid3),
    .s_last   (s_last),
    .s_addr   (s_addr),
    .s_ready  (s_ready3),
    .m_data   (m_data3),
    .m_last   (m_last3),
    .m_valid  (m_valid3),
    .m_ready  (m_ready[2:0]),
    .drop_err (drop_err3),
    .drop_cnt (drop_cnt3)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic v4, input logic v3, input logic [31:0] d,
                               input logic l, input logic [1:0] a, input int sink);
    s_valid4  = v4;
    s_valid3  = v3;
    s_data    = d;
    s_last    = l;
    s_addr    = a;
    beat_sink = sink;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkIdle4(input string tag);
    checkOutput(tag, 32'(m_valid4), 32'h0);
  endtask

  // Scoreboard for the NUM=4 instance. Inputs and ready are stable at the
  // falling edge, so a handshake seen here completes at the next rising edge.
  always @(negedge clock) begin
    if (rst) begin
      sb.delete();
    end else begin
      if (sb.size() == 0) begin
        checkOutput("sb_idle_valid", 32'(m_valid4), 32'h0);
      end else begin
        head = sb[0];
        checkOutput("sb_valid", 32'(m_valid4), 32'(4'b0001 << head.sink));
        checkOutput("sb_data",  m_data4, head.data);
        checkOutput("sb_last",  32'(m_last4), 32'(head.last));
        if (m_ready[head.sink]) begin
          void'(sb.pop_front());
        end
      end
      if (s_valid4 && s_ready4 && beat_sink >= 0) begin
        sb.push_back('{beat_sink, s_data, s_last});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    m_ready = 4'hF;
    applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    repeat (3) nextCycle();

    // Reset values
    @(negedge clock);
    checkOutput("rst_s_ready",  32'(s_ready4),  32'h0);
    checkOutput("rst_m_valid",  32'(m_valid4),  32'h0);
    checkOutput("rst_m_data",   m_data4,        32'h0);
    checkOutput("rst_m_last",   32'(m_last4),   32'h0);
    checkOutput("rst_drop_err", 32'(drop_err4), 32'h0);
    checkOutput("rst_drop_cnt", 32'(drop_cnt4), 32'h0);
    checkOutput("rst_s_ready3", 32'(s_ready3),  32'h0);
    nextCycle();
    rst = 1'b0;
    nextCycle();
    @(negedge clock);
    checkOutput("post_rst_s_ready",  32'(s_ready4), 32'h1);
    checkOutput("post_rst_s_ready3", 32'(s_ready3), 32'h1);

    // Three-beat frame to sink 2
    nextCycle(); applyStimulus(1, 0, 32'hA0, 0, 2'd2, 2);
    @(negedge clock); checkOutput("f1_s_ready0", 32'(s_ready4), 32'h1);
    nextCycle(); applyStimulus(1, 0, 32'hA1, 0, 2'd2, 2);
    @(negedge clock);
    checkOutput("f1_valid1", 32'(m_valid4), 32'h4);
    checkOutput("f1_data1",  m_data4, 32'hA0);
    checkOutput("f1_last1",  32'(m_last4), 32'h0);
    checkOutput("f1_s_ready1", 32'(s_ready4), 32'h1);
    nextCycle(); applyStimulus(1, 0, 32'hA2, 1, 2'd2, 2);
    @(negedge clock);
    checkOutput("f1_valid2", 32'(m_valid4), 32'h4);
    checkOutput("f1_data2",  m_data4, 32'hA1);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("f1_valid3", 32'(m_valid4), 32'h4);
    checkOutput("f1_data3",  m_data4, 32'hA2);
    checkOutput("f1_last3",  32'(m_last4), 32'h1);
    checkOutput("f1_s_ready3", 32'(s_ready4), 32'h1);
    nextCycle();
    @(negedge clock); checkIdle4("f1_done");

    // Back-to-back frames: sink 1 (addr changes mid-frame), then sink 3
    nextCycle(); applyStimulus(1, 0, 32'hB0, 0, 2'd1, 1);
    @(negedge clock);
    nextCycle(); applyStimulus(1, 0, 32'hB1, 1, 2'd0, 1);
    @(negedge clock);
    checkOutput("b2b_valid0", 32'(m_valid4), 32'h2);
    checkOutput("b2b_data0",  m_data4, 32'hB0);
    nextCycle(); applyStimulus(1, 0, 32'hC0, 1, 2'd3, 3);
    @(negedge clock);
    checkOutput("b2b_valid1", 32'(m_valid4), 32'h2);
    checkOutput("b2b_data1",  m_data4, 32'hB1);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("b2b_valid2", 32'(m_valid4), 32'h8);
    checkOutput("b2b_data2",  m_data4, 32'hC0);
    nextCycle();
    @(negedge clock); checkIdle4("b2b_done");

    // Backpressure on sink 0 for four cycles during a four-beat frame
    nextCycle(); m_ready = 4'hE; applyStimulus(1, 0, 32'hD0, 0, 2'd0, 0);
    @(negedge clock); checkOutput("bp_s_ready_a", 32'(s_ready4), 32'h1);
    nextCycle(); applyStimulus(1, 0, 32'hD1, 0, 2'd0, 0);
    @(negedge clock);
    checkOutput("bp_s_ready_b", 32'(s_ready4), 32'h1);
    checkOutput("bp_data_b",    m_data4, 32'hD0);
    nextCycle(); applyStimulus(1, 0, 32'hD2, 0, 2'd0, 0);
    @(negedge clock);
    checkOutput("bp_s_ready_c", 32'(s_ready4), 32'h0);
    checkOutput("bp_valid_c",   32'(m_valid4), 32'h1);
    nextCycle();
    @(negedge clock); checkOutput("bp_s_ready_d", 32'(s_ready4), 32'h0);
    nextCycle(); m_ready = 4'hF;
    @(negedge clock);
    checkOutput("bp_s_ready_e", 32'(s_ready4), 32'h0);
    checkOutput("bp_data_e",    m_data4, 32'hD0);
    nextCycle();
    @(negedge clock);
    checkOutput("bp_s_ready_f", 32'(s_ready4), 32'h1);
    checkOutput("bp_data_f",    m_data4, 32'hD1);
    nextCycle(); applyStimulus(1, 0, 32'hD3, 1, 2'd0, 0);
    @(negedge clock); checkOutput("bp_data_g", m_data4, 32'hD2);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("bp_data_h", m_data4, 32'hD3);
    checkOutput("bp_last_h", 32'(m_last4), 32'h1);
    nextCycle();
    @(negedge clock); checkIdle4("bp_done");

    // Illegal index on the NUM=3 instance, then a legal frame to sink 0
    nextCycle(); applyStimulus(0, 1, 32'hE0, 0, 2'd3, -1);
    @(negedge clock); checkOutput("drop_s_ready", 32'(s_ready3), 32'h1);
    nextCycle(); applyStimulus(0, 1, 32'hE1, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("drop_err_pulse", 32'(drop_err3), 32'h1);
    checkOutput("drop_cnt_1",     32'(drop_cnt3), 32'h1);
    checkOutput("drop_valid_b",   32'(m_valid3),  32'h0);
    nextCycle(); applyStimulus(0, 1, 32'hE2, 1, 2'd0, -1);
    @(negedge clock);
    checkOutput("drop_err_low",   32'(drop_err3), 32'h0);
    checkOutput("drop_valid_c",   32'(m_valid3),  32'h0);
    nextCycle(); applyStimulus(0, 1, 32'hF0, 1, 2'd0, -1);
    @(negedge clock);
    checkOutput("drop_valid_d",   32'(m_valid3),  32'h0);
    checkOutput("drop_cnt_d",     32'(drop_cnt3), 32'h1);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("after_drop_valid", 32'(m_valid3), 32'h1);
    checkOutput("after_drop_data",  m_data3, 32'hF0);
    checkOutput("after_drop_last",  32'(m_last3), 32'h1);
    checkOutput("after_drop_err",   32'(drop_err3), 32'h0);
    nextCycle();
    @(negedge clock);
    checkOutput("drop_done_valid", 32'(m_valid3), 32'h0);
    checkOutput("drop_done_cnt",   32'(drop_cnt3), 32'h1);

    // Two single-beat frames back to back, sink 1 then sink 2
    nextCycle(); applyStimulus(1, 0, 32'h10, 1, 2'd1, 1);
    @(negedge clock);
    nextCycle(); applyStimulus(1, 0, 32'h20, 1, 2'd2, 2);
    @(negedge clock);
    checkOutput("single_valid0", 32'(m_valid4), 32'h2);
    checkOutput("single_last0",  32'(m_last4), 32'h1);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("single_valid1", 32'(m_valid4), 32'h4);
    checkOutput("single_data1",  m_data4, 32'h20);
    nextCycle();
    @(negedge clock); checkIdle4("single_done");

    // Reset mid-frame with the skid full, then a fresh frame to sink 2
    nextCycle(); m_ready = 4'hB; applyStimulus(1, 0, 32'h30, 0, 2'd2, 2);
    @(negedge clock);
    nextCycle(); applyStimulus(1, 0, 32'h31, 0, 2'd2, 2);
    @(negedge clock); checkOutput("mid_valid", 32'(m_valid4), 32'h4);
    nextCycle(); applyStimulus(1, 0, 32'h32, 0, 2'd2, 2); rst = 1'b1;
    @(negedge clock); checkOutput("mid_skid_full", 32'(s_ready4), 32'h0);
    nextCycle(); rst = 1'b0; m_ready = 4'hF; applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("mid_rst_s_ready",  32'(s_ready4),  32'h0);
    checkOutput("mid_rst_m_valid",  32'(m_valid4),  32'h0);
    checkOutput("mid_rst_m_data",   m_data4,        32'h0);
    checkOutput("mid_rst_m_last",   32'(m_last4),   32'h0);
    checkOutput("mid_rst_drop_err", 32'(drop_err4), 32'h0);
    checkOutput("mid_rst_drop_cnt3", 32'(drop_cnt3), 32'h0);
    nextCycle();
    @(negedge clock); checkOutput("mid_rel_s_ready", 32'(s_ready4), 32'h1);
    nextCycle(); applyStimulus(1, 0, 32'h40, 0, 2'd2, 2);
    @(negedge clock);
    nextCycle(); applyStimulus(1, 0, 32'h41, 1, 2'd0, 2);
    @(negedge clock);
    checkOutput("new_valid0", 32'(m_valid4), 32'h4);
    checkOutput("new_data0",  m_data4, 32'h40);
    nextCycle(); applyStimulus(0, 0, 32'h0, 0, 2'd0, -1);
    @(negedge clock);
    checkOutput("new_valid1", 32'(m_valid4), 32'h4);
    checkOutput("new_data1",  m_data4, 32'h41);
    checkOutput("new_last1",  32'(m_last4), 32'h1);
    nextCycle();
    @(negedge clock);
    checkIdle4("new_done");
    checkOutput("sb_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/data_c_pipe_intc_s2m.md
Name: data_c_pipe_intc_S2M

Overview:
- Single-source to multi-sink frame router.
- Sits directly downstream of the multi-to-one pipe interconnect. It takes that merged stream plus a per-frame destination index and steers each whole frame to one of NUM sink ports.
- Fully pipelined: registered outputs, registered upstream ready, two-entry skid buffer, one beat per cycle sustained.
- Frames with an out-of-range destination are drained and counted.

Parameters:
- NUM, 4, number of sink ports (2..16).
- DSIZE, 32, data width in bits.
- NSIZE, derived as clog2(NUM) (minimum 1), width of the destination index.

Ports:
- clock  in  1  single clock; everything is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- s_data  in  DSIZE  upstream beat data.
- s_valid  in  1  upstream beat valid.
- s_last  in  1  final beat of the frame.
- s_addr  in  NSIZE  destination index; sampled only on the first beat of a frame.
- s_ready  out  1  upstream ready; registered.
- m_data  out  DSIZE  beat data, broadcast to all sinks.
- m_last  out  1  final-beat flag, broadcast to all sinks.
- m_valid  out  NUM  one-hot valid; bit i targets sink i.
- m_ready  in  NUM  per-sink ready.
- drop_err  out  1  one-cycle pulse when an illegal frame is opened.
- drop_cnt  out  16  saturating count of dropped frames.

Behaviour:
- Reset values: s_ready=0, m_valid=0, m_data=0, m_last=0, drop_err=0, drop_cnt=0. Both buffer entries are emptied and the route FSM goes to IDLE. Reset mid-frame discards all buffered beats and the open route.
- From the first cycle after rst deasserts, s_ready=1.
- Handshakes:
  - Upstream beat accepted when s_valid && s_ready.
  - Sink i beat accepted when m_valid[i] && m_ready[i].
  - m_valid[i] never depends combinationally on m_ready.
- Route FSM:
  - IDLE: on an accepted beat:
    - s_addr<NUM: route=s_addr, go to LOCK.
    - s_addr>=NUM: pulse drop_err, drop_cnt+1 (saturating at 16'hFFFF), go to DROP.
    - If that beat also has s_last, route still applies to the beat (or the beat is dropped), and the FSM stays in IDLE (single-beat frame).
  - LOCK: every accepted beat carries the locked route and s_addr is ignored. An accepted beat with s_last returns the FSM to IDLE.
  - DROP: accepted beats are discarded and never enter the buffer. s_ready stays governed only by buffer state. An accepted beat with s_last returns the FSM to IDLE.
- Buffer, two entries (out reg, skid reg), each holding {data, last, route, vld}:
  - Output: m_valid = out.vld ? onehot(out.route) : 0. m_data and m_last come from out.
  - Output pop: the out entry pops when m_ready[out.route] is high.
  - Accept with out empty, or out popping the same cycle: the beat loads the out reg directly. Latency is 1 cycle from accept to m_valid.
  - Accept while out is held: the beat goes to skid; next cycle s_ready=0.
  - When out pops and skid is valid: skid moves to out, and s_ready=1 the following cycle.
  - s_ready is registered as !skid.vld for the next cycle.
  - Sustained throughput is 1 beat/cycle when the target sink holds m_ready=1.
- Ordering and blocking:
  - Beats leave in acceptance order.
  - A stalled sink blocks all traffic (no reordering or bypass), including a following frame to a different sink.
- Dropped beats never assert any m_valid bit and cost 1 accepted beat per cycle.
- s_valid low mid-frame holds the route indefinitely.

Test Plan:
- Reset then a 3-beat frame, s_addr=2, data 0xA0,0xA1,0xA2, all m_ready=1:
  - m_valid=4'b0100 on cycles 1..3 after the first accept, m_last only with 0xA2.
  - s_ready stays 1 throughout.
- Back-to-back frames: addr 1 (2 beats) then addr 3 (1 beat), no gap:
  - m_valid goes 0010,0010,1000 on consecutive cycles.
  - s_addr is changed to 0 on the second beat of the first frame; it must be ignored.
- Backpressure with m_ready[0]=0 for 4 cycles during a 4-beat frame to sink 0:
  - Exactly 2 beats are accepted, then s_ready=0.
  - After release, all 4 beats arrive in order with no loss or duplication, and s_ready returns to 1 one cycle after the skid drains.
- Illegal address, NUM=4, addr 4 not representable: use NUM=3 with s_addr=3 and a 3-beat frame:
  - drop_err pulses once on the first beat, drop_cnt=1, m_valid stays 0.
  - The next frame, addr 0, routes normally.
- Single-beat frame (s_last on the first beat), addr 1, followed immediately by addr 2:
  - Two separate routes; FSM is IDLE between them.
- Reset asserted mid-frame with the skid full:
  - Next cycle all outputs are at reset values.
  - After release, a new frame to addr 2 routes correctly (no stale route or data).
